// File: rtl/debounce_pkg.sv
// Shared types and default parameters for the switch debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_N_STABLE    = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit; q is the last stage.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Bouncy-switch conditioner: synchronizer, stability counter and a 4-state
// FSM producing a clean registered level X plus one-cycle RISE/FALL strobes.
module switch_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int N_STABLE    = DEF_N_STABLE
) (
  input  logic clk,
  input  logic reset,
  input  logic BTN,
  output logic X,
  output logic RISE,
  output logic FALL
);

  localparam int CW = $clog2(N_STABLE + 1);
  localparam logic [CW-1:0] LAST = CW'(N_STABLE - 1);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4)
      $error("switch_debounce: SYNC_STAGES must be in 2..4");
    if (N_STABLE < 2)
      $error("switch_debounce: N_STABLE must be at least 2");
  endgenerate

  logic          s;
  logic [CW-1:0] cnt;
  state_t        state;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (BTN),
    .q     (s)
  );

  // cnt holds how many consecutive cycles s has sat at the candidate level;
  // reaching LAST with s still there on this edge makes N_STABLE in total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE_LO;
      cnt   <= '0;
      X     <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
    end else begin
      RISE <= 1'b0;
      FALL <= 1'b0;
      case (state)
        IDLE_LO: begin
          if (s) begin
            state <= WAIT_HI;
            cnt   <= CW'(1);
          end else begin
            cnt   <= '0;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE_HI;
            cnt   <= '0;
            X     <= 1'b1;
            RISE  <= 1'b1;
          end else begin
            cnt   <= cnt + CW'(1);
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state <= WAIT_LO;
            cnt   <= CW'(1);
          end else begin
            cnt   <= '0;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= IDLE_HI;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE_LO;
            cnt   <= '0;
            X     <= 1'b0;
            FALL  <= 1'b1;
          end else begin
            cnt   <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE_LO;
          cnt   <= '0;
          X     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce: per-cycle expected {X,RISE,FALL}
// queued by the stimulus and checked by an independent monitor.
`timescale 1ps/1ps
module tb_switch_debounce;

  logic clk = 1'b0;
  logic reset;
  logic BTN;
  logic X, RISE, FALL;

  switch_debounce dut (
    .clk   (clk),
    .reset (reset),
    .BTN   (BTN),
    .X     (X),
    .RISE  (RISE),
    .FALL  (FALL)
  );

  always #50 clk = ~clk;

  typedef struct {
    int    cyc;
    string name;
    logic  [2:0] xrf;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc=%0d got XRF=%b want XRF=%b", name, cyc, got, want);
  endtask

  // Monitor: every posedge, 1ps later, compare against whatever was queued for this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) chk({e.name, "_missed"}, 3'bxxx, e.xrf);
        else             chk(e.name, {X, RISE, FALL}, e.xrf);
      end
    end
  end

  // Expect {x,r,f} right after the next posedge.
  task automatic expect_next(input string name, input logic x, input logic r, input logic f);
    exp_t e;
    e.cyc  = cyc + 1;
    e.name = name;
    e.xrf  = {x, r, f};
    q.push_back(e);
  endtask

  task automatic step(input string name, input logic b, input logic x, input logic r, input logic f);
    @(negedge clk);
    BTN = b;
    expect_next(name, x, r, f);
  endtask

  task automatic run(input string name, input logic b, input int n,
                     input logic x, input logic r, input logic f);
    for (int i = 0; i < n; i++) step(name, b, x, r, f);
  endtask

  initial begin
    reset = 1'b0;
    BTN   = 1'b1;

    // Reset held with BTN high: outputs stay 0 at edges and mid-cycle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid", {X, RISE, FALL}, 3'b000);
      expect_next("rst_edge", 1'b0, 1'b0, 1'b0);
    end

    // Release with BTN held 1: X rises at E5 relative to first edge after release.
    @(negedge clk);
    reset = 1'b1;
    BTN   = 1'b1;
    expect_next("rel_hi_wait", 1'b0, 1'b0, 1'b0);
    run("rel_hi_wait", 1'b1, 4, 1'b0, 1'b0, 1'b0);
    step("rel_hi_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    run("rel_hi_hold", 1'b1, 2, 1'b1, 1'b0, 1'b0);

    // Clean release.
    run("release_wait", 1'b0, 5, 1'b1, 1'b0, 1'b0);
    step("release_fall", 1'b0, 1'b0, 1'b0, 1'b1);
    run("release_hold", 1'b0, 3, 1'b0, 1'b0, 1'b0);

    // Bounce 1,1,0,1,1,1,0: no excursion reaches 4 cycles.
    step("bounce_hi", 1'b1, 1'b0, 1'b0, 1'b0);
    step("bounce_hi", 1'b1, 1'b0, 1'b0, 1'b0);
    step("bounce_hi", 1'b0, 1'b0, 1'b0, 1'b0);
    run("bounce_hi", 1'b1, 3, 1'b0, 1'b0, 1'b0);
    run("bounce_hi", 1'b0, 6, 1'b0, 1'b0, 1'b0);

    // Excursion of exactly N_STABLE cycles is accepted, then released.
    run("exact4_wait", 1'b1, 4, 1'b0, 1'b0, 1'b0);
    step("exact4_wait", 1'b0, 1'b0, 1'b0, 1'b0);
    step("exact4_rise", 1'b0, 1'b1, 1'b1, 1'b0);
    run("exact4_hi", 1'b0, 3, 1'b1, 1'b0, 1'b0);
    step("exact4_fall", 1'b0, 1'b0, 1'b0, 1'b1);
    run("exact4_lo", 1'b0, 2, 1'b0, 1'b0, 1'b0);

    // Clean press.
    run("press_wait", 1'b1, 5, 1'b0, 1'b0, 1'b0);
    step("press_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    run("press_hold", 1'b1, 2, 1'b1, 1'b0, 1'b0);

    // Low-going bounce of N_STABLE-1 cycles is rejected.
    run("bounce_lo", 1'b0, 3, 1'b1, 1'b0, 1'b0);
    run("bounce_lo", 1'b1, 6, 1'b1, 1'b0, 1'b0);

    // Clean release.
    run("release2_wait", 1'b0, 5, 1'b1, 1'b0, 1'b0);
    step("release2_fall", 1'b0, 1'b0, 1'b0, 1'b1);
    run("release2_hold", 1'b0, 3, 1'b0, 1'b0, 1'b0);

    // Reset between E3 and E4 of a pending press, released one cycle later.
    run("rstmid_pre", 1'b1, 4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rstmid_async", {X, RISE, FALL}, 3'b000);
    expect_next("rstmid_held", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    expect_next("rstmid_wait", 1'b0, 1'b0, 1'b0);
    run("rstmid_wait", 1'b1, 4, 1'b0, 1'b0, 1'b0);
    step("rstmid_rise", 1'b1, 1'b1, 1'b1, 1'b0);
    run("rstmid_hold", 1'b1, 2, 1'b1, 1'b0, 1'b0);

    // Reset during a pending release: X drops to 0 immediately, no FALL.
    run("rstlo_pre", 1'b0, 3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rstlo_async", {X, RISE, FALL}, 3'b000);
    expect_next("rstlo_held", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    expect_next("rstlo_after", 1'b0, 1'b0, 1'b0);
    run("rstlo_after", 1'b0, 6, 1'b0, 1'b0, 1'b0);

    // Drain with a bounded wait; leftover expectations count as failures.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain pending=%0d want=0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
